// File: rtl/arq_pkg.sv
// Shared types and default constants for the ARQ sender and its timeout timer.
package arq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arq_state_t;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Keeps the counter at least one bit wide when the timeout is a single cycle.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/arq_timer.sv
// WAIT-phase timeout counter: counts enabled cycles and flags the last one.
module arq_timer
  import arq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              TW   = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/arq_sender.sv
// Stop-and-wait ARQ sender: holds one word, strobes it downstream and retries
// on nack or timeout until delivered or the retry budget is spent.
module arq_sender
  import arq_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack,
  input  logic                  nack,
  output logic                  sent,
  output logic                  fail,
  output logic [1:0]            retry_cnt
);

  localparam logic [1:0] MAX_RC = 2'(MAX_RETRIES);

  arq_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_sent;
  logic                  r_fail;
  logic [1:0]            r_retry_cnt;

  logic w_timer_en;
  logic w_timer_clear;
  logic w_expired;
  logic w_attempt_failed;

  assign w_timer_en    = (r_state == ST_WAIT);
  assign w_timer_clear = !w_timer_en;

  arq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  // A simultaneous ack+nack falls through to the retry path as a nack.
  assign w_attempt_failed = nack || w_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_sent      <= 1'b0;
      r_fail      <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_sent <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (src_valid) begin
            r_hold      <= src_data;
            r_retry_cnt <= '0;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ack && !nack) begin
            r_sent  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_attempt_failed) begin
            if (r_retry_cnt < MAX_RC) begin
              r_retry_cnt <= r_retry_cnt + 2'd1;
              r_state     <= ST_SEND;
            end else begin
              r_fail  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_ready = (r_state == ST_IDLE);
  assign wr_en     = (r_state == ST_SEND);
  assign data_out  = r_hold;
  assign sent      = r_sent;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_arq_sender.sv
// Directed-vector bench for arq_sender: table of per-cycle vectors plus
// hand-written timeout and mid-WAIT reset sequences.
module tb_arq_sender;
  import arq_pkg::*;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       srcValid = 1'b0;
  logic [7:0] srcData  = 8'h00;
  logic       ackIn    = 1'b0;
  logic       nackIn   = 1'b0;

  logic       srcReady;
  logic       wrEn;
  logic [7:0] dataOut;
  logic       sentOut;
  logic       failOut;
  logic [1:0] retryCnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       rstN;
    logic       valid;
    logic [7:0] data;
    logic       ackV;
    logic       nackV;
    logic       expWr;
    logic [7:0] expData;
    logic       expReady;
    logic       expSent;
    logic       expFail;
    logic [1:0] expRetry;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  arq_sender #(
    .DATA_WIDTH    (8),
    .MAX_RETRIES   (3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_valid(srcValid),
    .src_data (srcData),
    .src_ready(srcReady),
    .wr_en    (wrEn),
    .data_out (dataOut),
    .ack      (ackIn),
    .nack     (nackIn),
    .sent     (sentOut),
    .fail     (failOut),
    .retry_cnt(retryCnt)
  );

  function automatic vec_t mk(input string n, input logic r, input logic v,
                              input logic [7:0] d, input logic a, input logic nk,
                              input logic w, input logic [7:0] ed, input logic rd,
                              input logic s, input logic f, input logic [1:0] rc);
    vec_t t;
    t.name = n; t.rstN = r; t.valid = v; t.data = d; t.ackV = a; t.nackV = nk;
    t.expWr = w; t.expData = ed; t.expReady = rd; t.expSent = s; t.expFail = f;
    t.expRetry = rc;
    return t;
  endfunction

  task automatic checkValue(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic w, input logic [7:0] d,
                             input logic rd, input logic s, input logic f,
                             input logic [1:0] rc);
    checkValue({tag, ".wr_en"},     32'(wrEn),     32'(w));
    checkValue({tag, ".data_out"},  32'(dataOut),  32'(d));
    checkValue({tag, ".src_ready"}, 32'(srcReady), 32'(rd));
    checkValue({tag, ".sent"},      32'(sentOut),  32'(s));
    checkValue({tag, ".fail"},      32'(failOut),  32'(f));
    checkValue({tag, ".retry_cnt"}, 32'(retryCnt), 32'(rc));
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                               input logic a, input logic nk);
    rst_n    = r;
    srcValid = v;
    srcData  = d;
    ackIn    = a;
    nackIn   = nk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       expWr;
    logic       expFail;
    logic       expReady;
    logic [1:0] expRc;

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);

    vecs.push_back(mk("a5_accept", 1,1,8'hA5,0,0, 1,8'hA5,0,0,0,2'd0));
    vecs.push_back(mk("a5_wait0",  1,0,8'h00,0,0, 0,8'hA5,0,0,0,2'd0));
    vecs.push_back(mk("a5_wait1",  1,0,8'h00,0,0, 0,8'hA5,0,0,0,2'd0));
    vecs.push_back(mk("a5_ack",    1,0,8'h00,1,0, 0,8'hA5,1,1,0,2'd0));
    vecs.push_back(mk("a5_idle",   1,0,8'h00,0,0, 0,8'hA5,1,0,0,2'd0));

    vecs.push_back(mk("3c_accept", 1,1,8'h3C,0,0, 1,8'h3C,0,0,0,2'd0));
    vecs.push_back(mk("3c_wait1",  1,0,8'h00,0,0, 0,8'h3C,0,0,0,2'd0));
    vecs.push_back(mk("3c_nack1",  1,0,8'h00,0,1, 1,8'h3C,0,0,0,2'd1));
    vecs.push_back(mk("3c_wait2",  1,0,8'h00,0,0, 0,8'h3C,0,0,0,2'd1));
    vecs.push_back(mk("3c_nack2",  1,0,8'h00,0,1, 1,8'h3C,0,0,0,2'd2));
    vecs.push_back(mk("3c_srcchg", 1,1,8'hFF,0,0, 0,8'h3C,0,0,0,2'd2));
    vecs.push_back(mk("3c_ack",    1,0,8'h00,1,0, 0,8'h3C,1,1,0,2'd2));

    vecs.push_back(mk("55_b2b",     1,1,8'h55,0,0, 1,8'h55,0,0,0,2'd0));
    vecs.push_back(mk("55_wait1",   1,0,8'h00,0,0, 0,8'h55,0,0,0,2'd0));
    vecs.push_back(mk("55_acknack", 1,0,8'h00,1,1, 1,8'h55,0,0,0,2'd1));
    vecs.push_back(mk("55_wait2",   1,0,8'h00,0,0, 0,8'h55,0,0,0,2'd1));
    vecs.push_back(mk("55_ack",     1,0,8'h00,1,0, 0,8'h55,1,1,0,2'd1));
    vecs.push_back(mk("idle_ack",   1,0,8'h00,1,0, 0,8'h55,1,0,0,2'd1));
    vecs.push_back(mk("idle_nack",  1,0,8'h00,0,1, 0,8'h55,1,0,0,2'd1));

    vecs.push_back(mk("11_accept", 1,1,8'h11,0,0, 1,8'h11,0,0,0,2'd0));
    vecs.push_back(mk("11_wait1",  1,0,8'h00,0,0, 0,8'h11,0,0,0,2'd0));
    vecs.push_back(mk("11_nack1",  1,0,8'h00,0,1, 1,8'h11,0,0,0,2'd1));
    vecs.push_back(mk("11_wait2",  1,0,8'h00,0,0, 0,8'h11,0,0,0,2'd1));
    vecs.push_back(mk("11_nack2",  1,0,8'h00,0,1, 1,8'h11,0,0,0,2'd2));
    vecs.push_back(mk("11_wait3",  1,0,8'h00,0,0, 0,8'h11,0,0,0,2'd2));
    vecs.push_back(mk("11_nack3",  1,0,8'h00,0,1, 1,8'h11,0,0,0,2'd3));
    vecs.push_back(mk("11_wait4",  1,0,8'h00,0,0, 0,8'h11,0,0,0,2'd3));
    vecs.push_back(mk("11_nack4",  1,0,8'h00,0,1, 0,8'h11,1,0,1,2'd3));
    vecs.push_back(mk("11_after",  1,0,8'h00,0,0, 0,8'h11,1,0,0,2'd3));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].valid, vecs[i].data, vecs[i].ackV, vecs[i].nackV);
      checkOutput(vecs[i].name, vecs[i].expWr, vecs[i].expData, vecs[i].expReady,
                  vecs[i].expSent, vecs[i].expFail, vecs[i].expRetry);
    end

    // Silent receiver: one SEND plus 16 WAIT cycles per attempt, four attempts, then fail.
    applyStimulus(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    checkOutput("7e_t0", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int t = 1; t <= 72; t++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      expWr    = ((t % 17) == 0) && (t <= 51);
      expFail  = (t == 68);
      expReady = (t >= 68);
      expRc    = (t >= 51) ? 2'd3 : 2'(t / 17);
      checkOutput($sformatf("7e_t%0d", t), expWr, 8'h7E, expReady, 1'b0, expFail, expRc);
    end

    // Reset during WAIT drops the word silently; a late ack must not produce sent.
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("99_accept", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("99_retry", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("99_reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("99_late_ack", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("99_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arq_sender.md
ARQ_SENDER -- requirements
Module: arq_sender

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of payload word.
REQ-002 Parameter MAX_RETRIES, default 3, retransmissions allowed after the first send.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, WAIT cycles without ack/nack before the attempt counts as failed.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 src_valid  in  1  upstream word offered.
REQ-007 src_data  in  DATA_WIDTH  upstream word.
REQ-008 src_ready  out  1  block can accept a word.
REQ-009 wr_en  out  1  one-cycle write strobe to the downstream FIFO/ECC stage.
REQ-010 data_out  out  DATA_WIDTH  word presented with wr_en.
REQ-011 ack  in  1  downstream accepted word.
REQ-012 nack  in  1  downstream rejected word (ECC error or full).
REQ-013 sent  out  1  one-cycle pulse: word delivered.
REQ-014 fail  out  1  one-cycle pulse: word dropped after retries exhausted.
REQ-015 retry_cnt  out  2  retransmissions used for current word.

Function
REQ-016 States SHALL be IDLE, SEND, WAIT.
REQ-017 IDLE: src_ready=1; on edge with src_valid=1, src_data SHALL be captured into hold register, retry_cnt cleared, next state SEND.
REQ-018 SEND: wr_en=1 and data_out=hold for exactly one cycle; next state WAIT; timeout counter cleared.
REQ-019 Acceptance-to-strobe latency SHALL be 1 cycle (accept at edge N, wr_en high in cycle N..N+1).
REQ-020 WAIT: ack=1 and nack=0 -> sent pulse next cycle, state IDLE.
REQ-021 WAIT: nack=1, or timeout counter reaching TIMEOUT_CYCLES-1 -> if retry_cnt<MAX_RETRIES: retry_cnt+1, state SEND; else fail pulse, state IDLE, word dropped.
REQ-022 ack and nack in same cycle SHALL be treated as nack.
REQ-023 ack/nack outside WAIT SHALL be ignored.
REQ-024 src_ready SHALL be 0 in SEND and WAIT; src_data changes there have no effect.
REQ-025 data_out SHALL hold last word between strobes (no glitching to zero).
REQ-026 retry_cnt SHALL saturate at MAX_RETRIES; no wrap.
REQ-027 sent and fail SHALL never assert in same cycle.
REQ-028 Back-to-back: word accepted in the cycle IDLE is re-entered (sent/fail pulse cycle) when src_valid=1.

Reset
REQ-029 rst_n=0 at any edge SHALL force IDLE, wr_en=0, sent=0, fail=0, retry_cnt=0, data_out=0, hold=0, timer=0.
REQ-030 Reset mid-WAIT SHALL drop the in-flight word without fail pulse.
REQ-031 src_ready SHALL be 1 from first cycle after reset release.

Structure
REQ-032 Package arq_pkg SHALL hold state enum arq_state_t and default constants (DATA_WIDTH, MAX_RETRIES, TIMEOUT_CYCLES).
REQ-033 Timeout counter SHALL be sub-module arq_timer (clear, enable, expired), width clog2(TIMEOUT_CYCLES).
REQ-034 All outputs SHALL be registered or decoded from state register only.

Verification
REQ-035 Accept 0xA5, ack 2 cycles after wr_en -> one wr_en with data_out=0xA5, sent pulse, retry_cnt=0.
REQ-036 Word 0x3C, nack on first two attempts, ack on third -> three wr_en strobes of 0x3C, retry_cnt=2, sent pulse.
REQ-037 Word 0x11, nack every attempt -> four strobes, retry_cnt=3, fail pulse, src_ready=1 next cycle.
REQ-038 Word 0x7E, no response -> retransmit every 16 WAIT cycles, fail after fourth timeout.
REQ-039 ack+nack together on first attempt of 0x55 -> retransmission, no sent pulse that cycle.
REQ-040 rst_n=0 during WAIT of 0x99 -> all outputs zero next cycle, no fail, later ack ignored.
